// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, with 2-flop input synchroniser.
// Bit period is CLKS_PER_BIT+1 clk cycles. Each data bit is sampled in the middle of
// its bit period. The start bit is confirmed at its midpoint so that short glitches
// are rejected.
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing, which adds an even
// parity bit and the rx_parity_err pulse. Without the macro, rx_parity_err is tied to 0.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       rx_busy
);

  localparam int unsigned BitClks  = CLKS_PER_BIT + 1;
  localparam int unsigned Half     = BitClks / 2;
  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HalfLast = 16'(Half - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  state_e      state_q, state_d;

  // Synchroniser and edge-detect history. These reset high so the idle line never
  // looks like a start edge.
  logic        sync1_q, sync2_q, rx_prev_q;
  logic        rx_s;
  logic        fall;

  logic [15:0] clk_count_q, clk_count_d;
  logic [2:0]  bit_count_q, bit_count_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;

  logic        bit_tick;
  logic        half_tick;
  logic        par_bad;

`ifdef UART_RX_PARITY_EN
  logic        par_flag_q, par_flag_d;
  logic        parity_err_q, parity_err_d;
`endif

  assign rx_s      = sync2_q;
  assign fall      = rx_prev_q & ~rx_s;
  assign bit_tick  = (clk_count_q == BitLast);
  assign half_tick = (clk_count_q == HalfLast);

`ifdef UART_RX_PARITY_EN
  assign par_bad = par_flag_q;
`else
  assign par_bad = 1'b0;
`endif

  // Two-flop synchroniser plus one-cycle history of rx_s for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. Any illegal encoding falls back to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // Only a fresh 1->0 edge arms the receiver. A held-low line (break) does not.
        if (fall) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (half_tick) begin
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (bit_tick && (bit_count_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (bit_tick) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        // The FSM returns to idle at the stop bit's midpoint. This leaves half a bit
        // period to catch the start edge of a back-to-back frame.
        if (bit_tick) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath and output next-state logic. The pulse outputs default to 0 every cycle.
  always_comb begin
    clk_count_d = clk_count_q + 16'd1;
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = busy_q;
`ifdef UART_RX_PARITY_EN
    par_flag_d   = par_flag_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        clk_count_d = '0;
        if (fall) begin
          bit_count_d = '0;
          busy_d      = 1'b1;
`ifdef UART_RX_PARITY_EN
          par_flag_d  = 1'b0;
`endif
        end
      end
      StStart: begin
        if (half_tick) begin
          clk_count_d = '0;
          // The line went high again before mid-start, so this was a glitch.
          if (rx_s) begin
            busy_d = 1'b0;
          end
        end
      end
      StData: begin
        if (bit_tick) begin
          clk_count_d          = '0;
          shift_d[bit_count_q] = rx_s;
          bit_count_d          = bit_count_q + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (bit_tick) begin
          clk_count_d = '0;
          // Even parity: the received bit must equal the XOR of the data bits.
          par_flag_d  = par_flag_q | (rx_s != ^shift_q);
        end
      end
`endif
      StStop: begin
        if (bit_tick) begin
          clk_count_d = '0;
          busy_d      = 1'b0;
          if (rx_s && !par_bad) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          if (par_flag_q) begin
            parity_err_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        clk_count_d = '0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // Datapath and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_count_q <= '0;
      bit_count_q <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      clk_count_q <= clk_count_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity flags: a per-frame sticky mismatch flag and the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_flag_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_flag_q   <= par_flag_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rx_parity_err = parity_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = frame_err_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx. Stimulus pushes expected frame outcomes into a scoreboard
// queue. A negedge monitor pops one entry per output pulse and compares it.
module tb_uart_rx;

  localparam int unsigned CLKS_PER_BIT = 15;
  localparam int unsigned BIT_CLKS     = CLKS_PER_BIT + 1;
  localparam int unsigned HALF         = BIT_CLKS / 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned LAT = 2 + HALF + 10 * BIT_CLKS;
`else
  localparam int unsigned LAT = 2 + HALF + 9 * BIT_CLKS;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_busy;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  typedef struct {
    bit          valid;
    bit          ferr;
    bit          perr;
    logic [7:0]  data;
    bit          chk_lat;
    int unsigned t0;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the outcome of a whole frame, from its stop and parity bits.
  task automatic expect_frame(input logic [7:0] data, input bit stop, input bit par,
                              input bit chk_lat);
    exp_t e;
    bit   par_ok;
`ifdef UART_RX_PARITY_EN
    par_ok = (par == ^data);
`else
    par_ok = 1'b1;
`endif
    e.valid = stop && par_ok;
    e.ferr  = !stop;
    e.perr  = !par_ok;
    if (e.valid) last_good = data;
    e.data    = last_good;
    e.chk_lat = chk_lat;
    e.t0      = cyc;
    sb.push_back(e);
  endtask

  task automatic hold(input logic v, input int unsigned n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop, input bit par,
                            input bit chk_lat);
    expect_frame(data, stop, par, chk_lat);
    hold(1'b0, BIT_CLKS);
    check("busy_during_frame", rx_busy, 1'b1);
    for (int i = 0; i < 8; i++) hold(data[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    hold(par, BIT_CLKS);
`endif
    hold(stop, BIT_CLKS);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, rx_data, 8'h00);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_rx_frame_err"}, rx_frame_err, 1'b0);
    check({tag, "_rx_parity_err"}, rx_parity_err, 1'b0);
    check({tag, "_rx_busy"}, rx_busy, 1'b0);
  endtask

  // Monitor: each output pulse cycle consumes exactly one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (rx_valid || rx_frame_err || rx_parity_err)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: valid=%0b ferr=%0b perr=%0b data=0x%0h, expected none",
                 rx_valid, rx_frame_err, rx_parity_err, rx_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rx_valid", rx_valid, e.valid);
        check("rx_frame_err", rx_frame_err, e.ferr);
        check("rx_parity_err", rx_parity_err, e.perr);
        check("rx_data", rx_data, e.data);
        if (e.chk_lat) begin
          int unsigned lat;
          lat = cyc - e.t0;
          n_checks++;
          if (lat + 1 < LAT || lat > LAT + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, expected %0d +/-1", lat, LAT);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    bit         stop;
    bit         par;

    // Reset state
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    hold(1'b1, 5);

    // Single good byte, with a latency check
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1);
    hold(1'b1, 4);
    check("busy_after_a5", rx_busy, 1'b0);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, ^8'h00, 1'b0);
    send_frame(8'hFF, 1'b1, ^8'hFF, 1'b0);
    hold(1'b1, 4);

    // 4-cycle glitch: rejected at mid-start, busy must drop by cycle 2+HALF+1
    hold(1'b0, 4);
    hold(1'b1, 8);
    check("busy_after_glitch", rx_busy, 1'b0);
    hold(1'b1, BIT_CLKS);
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0);

    // Framing error followed by a break: no re-arm while the line stays low
    send_frame(8'h81, 1'b0, ^8'h81, 1'b0);
    hold(1'b0, 20);
    check("busy_during_break", rx_busy, 1'b0);
    hold(1'b0, 20);
    check("busy_after_break", rx_busy, 1'b0);
    check("rx_data_held_after_ferr", rx_data, 8'h3C);
    hold(1'b1, 2 * BIT_CLKS);

    // Asynchronous reset during bit 4 of 0x5A
    d = 8'h5A;
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) hold(d[i], BIT_CLKS);
    hold(d[4], BIT_CLKS / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 2 * BIT_CLKS);
    check("busy_after_reset_release", rx_busy, 1'b0);
    send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
    hold(1'b1, 3);

`ifdef UART_RX_PARITY_EN
    // Parity: a correct bit, a wrong bit, then a wrong bit together with a bad stop
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    send_frame(8'h37, 1'b0, ~^8'h37, 1'b0);
    hold(1'b1, 2 * BIT_CLKS);
`endif

    // Randomized frames with occasional bad stop/parity and random gaps
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par  = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, stop, par, 1'b0);
      // After a low stop bit, the line must go high before the next start edge can arm
      if (stop) hold(1'b1, $urandom_range(0, 20));
      else hold(1'b1, $urandom_range(2, 20));
    end
    hold(1'b1, 4);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 1000 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    check("busy_at_end", rx_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
